vc_buffer_bank: RTL and testbench

Per-input-port virtual-channel buffer bank: VC independent circular FIFOs in one parametrised block, with independent write-VC and read-VC selection, first-word-fall-through output, per-VC status and occupancy, a registered credit-return pulse, and sticky overflow/underflow flags. It sits between the router input link and the switch. The link side pushes flits tagged with a VC id. The control FSM/arbiter pops from whichever VC won allocation. Credits go back upstream for credit-based flow control.

---
 rtl/vc_buffer_bank.sv | 138 +++++++++++++
 tb/tb_vc_buffer_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vc_buffer_bank.sv
// Per-input-port virtual-channel buffer bank: VC independent circular FIFOs with
// first-word-fall-through read, per-VC status, registered credit return and sticky error flags.
module vc_buffer_bank #(
  parameter  int VC         = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 8,
  localparam int VCW        = $clog2(VC),
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [VCW-1:0]        wr_vc,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rd_en,
  input  logic [VCW-1:0]        rd_vc,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [VC-1:0]         empty_vc,
  output logic [VC-1:0]         full_vc,
  output logic [VC*CW-1:0]      count_vc,
  output logic                  credit_valid,
  output logic [VCW-1:0]        credit_vc,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] r_mem    [VC][FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr [VC];
  logic [PW-1:0]         r_rd_ptr [VC];
  logic [CW-1:0]         r_cnt    [VC];
  logic                  r_crd_vld_p1;
  logic [VCW-1:0]        r_crd_vc_p1;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_wr_vc_ok;
  logic                  w_rd_vc_ok;
  logic                  w_full_sel;
  logic                  w_empty_sel;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [VC-1:0]         w_push_vc;
  logic [VC-1:0]         w_pop_vc;
  logic [VC-1:0]         w_empty_vc;
  logic [VC-1:0]         w_full_vc;
  logic [DATA_WIDTH-1:0] w_head;
  logic [VC*CW-1:0]      w_count_vc;

  // VC ids past the last channel only exist when VC is not a power of two.
  generate
    if (VC == (1 << VCW)) begin : g_vc_pow2
      assign w_wr_vc_ok = 1'b1;
      assign w_rd_vc_ok = 1'b1;
    end else begin : g_vc_npow2
      assign w_wr_vc_ok = (wr_vc < VCW'(VC));
      assign w_rd_vc_ok = (rd_vc < VCW'(VC));
    end
  endgenerate

  always_comb begin
    w_empty_vc  = '0;
    w_full_vc   = '0;
    w_count_vc  = '0;
    w_full_sel  = 1'b0;
    w_empty_sel = 1'b1;
    w_head      = '0;
    for (int i = 0; i < VC; i++) begin
      w_empty_vc[i]            = (r_cnt[i] == '0);
      w_full_vc[i]             = (r_cnt[i] == CW'(FIFO_DEPTH));
      w_count_vc[i*CW +: CW]   = r_cnt[i];
      if (wr_vc == VCW'(i)) w_full_sel = w_full_vc[i];
      if (rd_vc == VCW'(i)) begin
        w_empty_sel = w_empty_vc[i];
        if (!w_empty_vc[i]) w_head = r_mem[i][r_rd_ptr[i]];
      end
    end
  end

  // A full VC may still take a push when the same VC is popped this cycle; no empty bypass.
  always_comb begin
    w_push_ok = wr_en & w_wr_vc_ok & (~w_full_sel | (rd_en & (rd_vc == wr_vc)));
    w_pop_ok  = rd_en & w_rd_vc_ok & ~w_empty_sel;
    w_push_vc = '0;
    w_pop_vc  = '0;
    for (int i = 0; i < VC; i++) begin
      w_push_vc[i] = w_push_ok & (wr_vc == VCW'(i));
      w_pop_vc[i]  = w_pop_ok  & (rd_vc == VCW'(i));
    end
  end

  // Stage p0 -> p1: control state, credit return and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < VC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_crd_vld_p1 <= 1'b0;
      r_crd_vc_p1  <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      for (int i = 0; i < VC; i++) begin
        if (w_push_vc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        if (w_pop_vc[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        if (w_push_vc[i] && !w_pop_vc[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push_vc[i] && w_pop_vc[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      r_crd_vld_p1 <= w_pop_ok;
      if (w_pop_ok) r_crd_vc_p1 <= rd_vc;
      if (wr_en && !w_push_ok) r_ovf <= 1'b1;
      if (rd_en && !w_pop_ok)  r_unf <= 1'b1;
    end
  end

  // Flit storage carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < VC; i++) begin
      if (w_push_vc[i]) r_mem[i][r_wr_ptr[i]] <= din;
    end
  end

  assign full         = w_full_sel;
  assign empty        = w_empty_sel;
  assign dout         = w_head;
  assign empty_vc     = w_empty_vc;
  assign full_vc      = w_full_vc;
  assign count_vc     = w_count_vc;
  assign credit_valid = r_crd_vld_p1;
  assign credit_vc    = r_crd_vc_p1;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_vc_buffer_bank.sv
// Scoreboard bench for vc_buffer_bank: per-VC expected-flit queues, credit and flag model.
module tb_vc_buffer_bank;
  localparam int VC = 4;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_vc = '0;
  logic [DW-1:0] din = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_vc = '0;
  logic [DW-1:0] dout;
  logic          empty;
  logic [VC-1:0] empty_vc;
  logic [VC-1:0] full_vc;
  logic [VC*CW-1:0] count_vc;
  logic          credit_valid;
  logic [1:0]    credit_vc;
  logic          overflow;
  logic          underflow;

  vc_buffer_bank #(.VC(VC), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din), .full(full),
    .rd_en(rd_en), .rd_vc(rd_vc), .dout(dout), .empty(empty), .empty_vc(empty_vc),
    .full_vc(full_vc), .count_vc(count_vc), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sbq [VC][$];
  logic          exp_ovf, exp_unf, exp_cv;
  logic [1:0]    exp_cvc;
  int            n_checks = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [VC*CW-1:0] ec;
    logic [VC-1:0]    ee, ef;
    ec = '0; ee = '0; ef = '0;
    for (int i = 0; i < VC; i++) begin
      ec[i*CW +: CW] = CW'(sbq[i].size());
      ee[i] = (sbq[i].size() == 0);
      ef[i] = (sbq[i].size() == D);
    end
    check_eq("count_vc", count_vc, ec);
    check_eq("empty_vc", empty_vc, ee);
    check_eq("full_vc", full_vc, ef);
    check_eq("credit_valid", credit_valid, exp_cv);
    check_eq("credit_vc", credit_vc, exp_cvc);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("underflow", underflow, exp_unf);
  endtask

  // Drive one cycle (entered just after a rising edge), check combinational view, then state.
  task automatic cycle(input bit we, input logic [1:0] wvc, input logic [DW-1:0] d,
                       input bit re, input logic [1:0] rvc);
    bit            push_ok, pop_ok;
    logic [DW-1:0] head;
    wr_en = we; wr_vc = wvc; din = d; rd_en = re; rd_vc = rvc;
    #1;
    head = (sbq[rvc].size() > 0) ? sbq[rvc][0] : '0;
    check_eq("dout", dout, head);
    check_eq("empty", empty, sbq[rvc].size() == 0);
    check_eq("full", full, sbq[wvc].size() == D);
    pop_ok  = re && (sbq[rvc].size() > 0);
    push_ok = we && ((sbq[wvc].size() < D) || (re && (rvc == wvc)));
    if (we && !push_ok) exp_ovf = 1'b1;
    if (re && !pop_ok)  exp_unf = 1'b1;
    if (pop_ok)  void'(sbq[rvc].pop_front());
    if (push_ok) sbq[wvc].push_back(d);
    exp_cv = pop_ok;
    if (pop_ok) exp_cvc = rvc;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_state();
  endtask

  // Reset cycle with a push and pop in flight; neither may take effect.
  task automatic do_reset(input logic [1:0] wvc, input logic [1:0] rvc);
    rst = 1'b0; wr_en = 1'b1; wr_vc = wvc; din = 32'hDEAD_BEEF; rd_en = 1'b1; rd_vc = rvc;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd_vc = 2'd0;
    for (int i = 0; i < VC; i++) sbq[i].delete();
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_cv = 1'b0; exp_cvc = 2'd0;
    check_state();
    check_eq("reset_dout", dout, 0);
  endtask

  initial begin
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_cv = 1'b0; exp_cvc = 2'd0;
    do_reset(2'd0, 2'd0);

    // Fill VC2, then one push too many
    for (int k = 0; k < D; k++) cycle(1, 2'd2, 32'h100 + k, 0, 2'd0);
    check_eq("fill_full_vc", full_vc, 4'b0100);
    check_eq("fill_empty_vc", empty_vc, 4'b1011);
    check_eq("fill_cnt2", count_vc[2*CW +: CW], 8);
    cycle(1, 2'd2, 32'h1FF, 0, 2'd0);
    check_eq("ovf_set", overflow, 1);

    // Drain VC2 with continuous credits, then observe empty head
    for (int k = 0; k < D; k++) cycle(0, 2'd0, '0, 1, 2'd2);
    cycle(0, 2'd0, '0, 0, 2'd2);
    check_eq("drained_empty", empty, 1);

    // Pop from empty VC0 while pushing it: no bypass
    cycle(1, 2'd0, 32'hA5A5_0001, 1, 2'd0);
    check_eq("unf_set", underflow, 1);
    cycle(0, 2'd0, '0, 0, 2'd0);

    // Full VC1 with simultaneous push/pop across wrap
    do_reset(2'd1, 2'd0);
    for (int k = 0; k < D; k++) cycle(1, 2'd1, 32'h200 + k, 0, 2'd1);
    for (int k = 0; k < 10; k++) cycle(1, 2'd1, 32'h300 + k, 1, 2'd1);
    check_eq("pp_ovf_clear", overflow, 0);
    for (int k = 0; k < D; k++) cycle(0, 2'd0, '0, 1, 2'd1);

    // Interleaved VC3 push / VC0 pop, swapping direction every 4 cycles
    for (int k = 0; k < 4; k++) cycle(1, 2'd0, $urandom, 0, 2'd0);
    for (int k = 0; k < 24; k++) begin
      if (((k / 4) % 2) == 0) cycle(1, 2'd3, $urandom, 1, 2'd0);
      else                    cycle(1, 2'd0, $urandom, 1, 2'd3);
    end

    // Random mixed traffic
    for (int k = 0; k < 80; k++)
      cycle(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
            bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    // Mid-burst reset
    do_reset(2'd1, 2'd0);
    for (int k = 0; k < 3; k++) cycle(1, 2'd1, 32'h400 + k, 1, 2'd2);
    for (int k = 0; k < 3; k++) cycle(0, 2'd0, '0, 0, 2'd1);
    do_reset(2'd1, 2'd1);
    cycle(0, 2'd0, '0, 0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
